// File: rtl/lynx_ps2_keymatrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lynx_ps2_keymatrix: PS/2 key events -> Lynx 48K 10x8 active-low matrix     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lynx_ps2_keymatrix #(
  parameter logic [23:0] RELEASE_DELAY = 24'd200000,
  parameter int          RQ_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset_osd,
  input  logic [10:0] ps2_key,
  input  logic [3:0]  row_sel,
  output logic [7:0]  col_n,
  output logic        key_any,
  output logic        rq_full
);
  localparam int AW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic            shadow, armed;
  logic [23:0]     stamp;
  logic            s1_valid, s1_press;
  logic [6:0]      s1_idx;
  logic            lut_hit;
  logic [6:0]      lut_idx;
  logic [9:0][7:0] matrix;

  logic [6:0]          q_idx   [RQ_DEPTH];
  logic [23:0]         q_stamp [RQ_DEPTH];
  logic [RQ_DEPTH-1:0] q_valid;
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;

  logic        ev, push, press, full, head_present, pop, clr_en;
  logic [23:0] head_age;

  // Shadow is only trusted after the first post-reset sample (armed).
  assign ev           = armed & (ps2_key[10] ^ shadow);
  assign push         = s1_valid & ~s1_press;
  assign press        = s1_valid & s1_press;
  assign full         = (count == CW'(RQ_DEPTH));
  assign head_present = (count != '0);
  assign head_age     = stamp - q_stamp[rd_ptr];
  assign pop          = (head_present & (~q_valid[rd_ptr] | (head_age >= RELEASE_DELAY)))
                      | (push & full);
  assign clr_en       = pop & q_valid[rd_ptr];

  always_comb begin
    lut_hit = 1'b1;
    lut_idx = '0;
    case ({ps2_key[8], ps2_key[7:0]})
      9'h012, 9'h059: lut_idx = 7'd0;
      9'h076: lut_idx = 7'd1;   9'h016: lut_idx = 7'd2;   9'h01E: lut_idx = 7'd3;
      9'h026: lut_idx = 7'd4;   9'h025: lut_idx = 7'd5;   9'h02E: lut_idx = 7'd6;
      9'h036: lut_idx = 7'd7;   9'h014: lut_idx = 7'd8;   9'h015: lut_idx = 7'd9;
      9'h01D: lut_idx = 7'd10;  9'h024: lut_idx = 7'd11;  9'h02D: lut_idx = 7'd12;
      9'h02C: lut_idx = 7'd13;  9'h035: lut_idx = 7'd14;  9'h03C: lut_idx = 7'd15;
      9'h058: lut_idx = 7'd16;  9'h043: lut_idx = 7'd17;  9'h044: lut_idx = 7'd18;
      9'h04D: lut_idx = 7'd19;  9'h03D: lut_idx = 7'd20;  9'h03E: lut_idx = 7'd21;
      9'h046: lut_idx = 7'd22;  9'h045: lut_idx = 7'd23;  9'h023: lut_idx = 7'd24;
      9'h01B: lut_idx = 7'd25;  9'h01C: lut_idx = 7'd26;  9'h02B: lut_idx = 7'd27;
      9'h034: lut_idx = 7'd28;  9'h033: lut_idx = 7'd29;  9'h03B: lut_idx = 7'd30;
      9'h042: lut_idx = 7'd31;  9'h04B: lut_idx = 7'd32;  9'h04C: lut_idx = 7'd33;
      9'h052: lut_idx = 7'd34;  9'h05A: lut_idx = 7'd35;  9'h01A: lut_idx = 7'd36;
      9'h022: lut_idx = 7'd37;  9'h021: lut_idx = 7'd38;  9'h02A: lut_idx = 7'd39;
      9'h032: lut_idx = 7'd40;  9'h031: lut_idx = 7'd41;  9'h03A: lut_idx = 7'd42;
      9'h041: lut_idx = 7'd43;  9'h049: lut_idx = 7'd44;  9'h04A: lut_idx = 7'd45;
      9'h04E: lut_idx = 7'd46;  9'h055: lut_idx = 7'd47;  9'h066: lut_idx = 7'd48;
      9'h054: lut_idx = 7'd49;  9'h05B: lut_idx = 7'd50;  9'h05D: lut_idx = 7'd51;
      9'h00D: lut_idx = 7'd52;  9'h00E: lut_idx = 7'd53;  9'h005: lut_idx = 7'd56;
      9'h006: lut_idx = 7'd57;  9'h00C: lut_idx = 7'd58;  9'h004: lut_idx = 7'd59;
      9'h171: lut_idx = 7'd64;  9'h16C: lut_idx = 7'd65;  9'h175: lut_idx = 7'd68;
      9'h16B: lut_idx = 7'd69;  9'h174: lut_idx = 7'd70;  9'h172: lut_idx = 7'd71;
      9'h029: lut_idx = 7'd72;
      default: lut_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      shadow   <= 1'b0;
      armed    <= 1'b0;
      stamp    <= '0;
      s1_valid <= 1'b0;
      s1_press <= 1'b0;
      s1_idx   <= '0;
    end else begin
      shadow   <= ps2_key[10];
      armed    <= 1'b1;
      stamp    <= stamp + 24'd1;
      s1_valid <= ev & lut_hit;
      s1_press <= ps2_key[9];
      s1_idx   <= lut_idx;
    end
  end

  // A press in the same cycle as a drain clear of the same key wins (last NBA).
  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      matrix  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      q_valid <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) begin
        q_idx[i]   <= '0;
        q_stamp[i] <= '0;
      end
    end else begin
      if (clr_en) matrix[q_idx[rd_ptr][6:3]][q_idx[rd_ptr][2:0]] <= 1'b0;
      if (press)  matrix[s1_idx[6:3]][s1_idx[2:0]] <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        q_idx[wr_ptr]   <= s1_idx;
        q_stamp[wr_ptr] <= stamp;
        q_valid[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (press) begin
        for (int i = 0; i < RQ_DEPTH; i++) begin
          if (q_idx[i] == s1_idx) q_valid[i] <= 1'b0;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      col_n   <= 8'hFF;
      key_any <= 1'b0;
      rq_full <= 1'b0;
    end else begin
      col_n   <= (row_sel <= 4'd9) ? ~matrix[row_sel] : 8'hFF;
      key_any <= |matrix;
      rq_full <= full;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lynx_ps2_keymatrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lynx_ps2_keymatrix: scoreboard bench for lynx_ps2_keymatrix             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lynx_ps2_keymatrix;
  logic        clock = 1'b0;
  logic        reset_osd = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [3:0]  row_sel = 4'd3;
  logic [7:0]  col_n;
  logic        key_any;
  logic        rq_full;

  lynx_ps2_keymatrix #(.RELEASE_DELAY(24'd100), .RQ_DEPTH(4)) dut (
    .clock(clock), .reset_osd(reset_osd), .ps2_key(ps2_key), .row_sel(row_sel),
    .col_n(col_n), .key_any(key_any), .rq_full(rq_full)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [7:0] col;
    logic       any;
    logic       full;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;
  exp_t  m_e;
  string m_n;

  // Expected outputs are queued against the cycle they must appear in.
  task automatic expect_at(input int d, input logic [7:0] col, input logic any,
                           input logic full, input string name);
    exp_t e;
    int   k;
    e.cyc = cyc + d; e.col = col; e.any = any; e.full = full;
    k = 0;
    while (k < exp_q.size() && exp_q[k].cyc <= e.cyc) k++;
    exp_q.insert(k, e);
    name_q.insert(k, name);
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      checks++;
      if (m_e.cyc != cyc || col_n !== m_e.col || key_any !== m_e.any || rq_full !== m_e.full) begin
        failures++;
        $display("FAIL %s cyc=%0d (want %0d) got col_n=%h key_any=%b rq_full=%b want col_n=%h key_any=%b rq_full=%b",
                 m_n, cyc, m_e.cyc, col_n, key_any, rq_full, m_e.col, m_e.any, m_e.full);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] code, input logic ext, input logic pr);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  int w;

  initial begin
    tick(3);
    expect_at(0, 8'hFF, 1'b0, 1'b0, "reset");
    tick(2);
    reset_osd = 1'b1;
    tick(3);

    // T1 / T2: press then delayed release of 'A' (row 3 col 2)
    send(8'h1C, 1'b0, 1'b1);
    expect_at(2, 8'hFF, 1'b0, 1'b0, "t1_latency");
    expect_at(3, 8'hFB, 1'b1, 1'b0, "t1_press");
    tick(10);
    send(8'h1C, 1'b0, 1'b0);
    expect_at(50,  8'hFB, 1'b1, 1'b0, "t2_mid");
    expect_at(102, 8'hFB, 1'b1, 1'b0, "t2_hold");
    expect_at(103, 8'hFF, 1'b0, 1'b0, "t2_clear");
    tick(110);

    // T3: re-press inside the delay window keeps the key down
    send(8'h1C, 1'b0, 1'b1);
    tick(5);
    send(8'h1C, 1'b0, 1'b0);
    expect_at(3, 8'hFB, 1'b1, 1'b0, "t3_rel");
    tick(10);
    send(8'h1C, 1'b0, 1'b1);
    expect_at(95,  8'hFB, 1'b1, 1'b0, "t3_hold_a");
    expect_at(150, 8'hFB, 1'b1, 1'b0, "t3_hold_b");
    tick(155);
    send(8'h1C, 1'b0, 1'b0);
    expect_at(103, 8'hFF, 1'b0, 1'b0, "t3_clear");
    tick(110);

    // T4: five releases into a four-deep FIFO (row 3: D S A F G)
    send(8'h23, 1'b0, 1'b1); tick(1);
    send(8'h1B, 1'b0, 1'b1); tick(1);
    send(8'h1C, 1'b0, 1'b1); tick(1);
    send(8'h2B, 1'b0, 1'b1); tick(1);
    send(8'h34, 1'b0, 1'b1); tick(5);
    expect_at(0, 8'hE0, 1'b1, 1'b0, "t4_held");
    send(8'h23, 1'b0, 1'b0); tick(1);
    send(8'h1B, 1'b0, 1'b0); tick(1);
    send(8'h1C, 1'b0, 1'b0); tick(1);
    send(8'h2B, 1'b0, 1'b0);
    expect_at(2, 8'hE0, 1'b1, 1'b0, "t4_not_full");
    expect_at(3, 8'hE0, 1'b1, 1'b1, "t4_full");
    tick(1);
    send(8'h34, 1'b0, 1'b0);
    expect_at(3,   8'hE1, 1'b1, 1'b1, "t4_force");
    expect_at(20,  8'hE1, 1'b1, 1'b1, "t4_others");
    expect_at(110, 8'hFF, 1'b0, 1'b0, "t4_drained");
    tick(115);

    // T5: extended vs plain 0x75, LEFT, out-of-range row
    row_sel = 4'd8;
    tick(2);
    send(8'h75, 1'b1, 1'b1);
    expect_at(3, 8'hEF, 1'b1, 1'b0, "t5_ext");
    tick(5);
    send(8'h75, 1'b0, 1'b1);
    expect_at(3, 8'hEF, 1'b1, 1'b0, "t5_nonext");
    tick(5);
    send(8'h6B, 1'b1, 1'b1);
    expect_at(3, 8'hCF, 1'b1, 1'b0, "t5_left");
    tick(5);
    row_sel = 4'd12;
    expect_at(1, 8'hFF, 1'b1, 1'b0, "t5_row12");
    tick(3);
    row_sel = 4'd8;
    expect_at(1, 8'hCF, 1'b1, 1'b0, "t5_row8");
    tick(3);
    send(8'h75, 1'b1, 1'b0); tick(1);
    send(8'h6B, 1'b1, 1'b0);
    expect_at(103, 8'hFF, 1'b0, 1'b0, "t5_clear");
    tick(110);

    // T6: reset while SPACE+SHIFT held and a release is pending
    row_sel = 4'd9;
    tick(2);
    send(8'h29, 1'b0, 1'b1); tick(1);
    send(8'h12, 1'b0, 1'b1); tick(5);
    expect_at(0, 8'hFE, 1'b1, 1'b0, "t6_space");
    send(8'h29, 1'b0, 1'b0);
    tick(20);
    reset_osd = 1'b0;
    expect_at(0, 8'hFF, 1'b0, 1'b0, "t6_reset");
    row_sel = 4'd0;
    send(8'h12, 1'b0, 1'b1);
    tick(3);
    reset_osd = 1'b1;
    expect_at(1, 8'hFF, 1'b0, 1'b0, "t6_no_event_a");
    expect_at(4, 8'hFF, 1'b0, 1'b0, "t6_no_event_b");
    expect_at(6, 8'hFF, 1'b0, 1'b0, "t6_no_event_c");
    tick(8);
    row_sel = 4'd9;
    send(8'h29, 1'b0, 1'b0);
    expect_at(5, 8'hFF, 1'b0, 1'b0, "t6_stale_release");
    tick(8);
    row_sel = 4'd3;
    send(8'h1C, 1'b0, 1'b1);
    expect_at(3, 8'hFB, 1'b1, 1'b0, "t6_after");
    tick(5);

    w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      tick(1);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
